// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the byte-serial key-load transmitter.
// Contents: FSM state encoding, default key length, byte width.
// Imported by key_sender_if, key_sender and gap_timer users.
package key_pkg;

    localparam int KEY_BYTES_DEF = 4;
    localparam int BYTE_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/key_sender_if.sv
// key_sender_if: host request + byte-serial key-load bus between host/sink and key_sender.
// master = key_sender side (takes key_in/start/dready, drives beat outputs); slave = host/sink side.
// Signals: key_in, start, busy, dout, dvalid, dready, sl, kset, pbeat, done.
interface key_sender_if #(
    parameter int KEY_BYTES = key_pkg::KEY_BYTES_DEF
) ();
    localparam int SLW = $clog2(KEY_BYTES);

    logic [key_pkg::BYTE_W*KEY_BYTES-1:0] key_in;
    logic                                 start;
    logic                                 busy;
    logic [key_pkg::BYTE_W-1:0]           dout;
    logic                                 dvalid;
    logic                                 dready;
    logic [SLW-1:0]                       sl;
    logic                                 kset;
    logic                                 pbeat;
    logic                                 done;

    modport master (
        input  key_in, start, dready,
        output busy, dout, dvalid, sl, kset, pbeat, done
    );

    modport slave (
        output key_in, start, dready,
        input  busy, dout, dvalid, sl, kset, pbeat, done
    );

endinterface

// File: rtl/key_sender_gap_timer.sv
// gap_timer: loadable 4-bit down-counter timing the idle gap between key beats.
// Latency: load takes effect next cycle; expired is high while the count is 1 (or 0).
// Ports: clk, rst_n (async active-low), load/load_val, en (decrement), expired.
module gap_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       expired
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Gap ends on the cycle the count reaches 1, giving exactly load_val idle cycles.
    assign expired = (cnt_q <= 4'd1);

endmodule

// File: rtl/key_sender.sv
// key_sender: latches a key word on start and streams it one byte per beat with a slot index.
// Latency: first beat the cycle after start; done pulses the cycle after the last accepted beat.
// Backpressure: dready=0 holds dout/sl indefinitely; optional parity beat under `KEY_PARITY_EN.
// Ports: dclk, reset (async active-low), bus (key_sender_if.master).
module key_sender
    import key_pkg::*;
#(
    parameter  int KEY_BYTES  = KEY_BYTES_DEF,
    parameter  int GAP_CYCLES = 0,
    localparam int SLW        = $clog2(KEY_BYTES)
) (
    input  logic         dclk,
    input  logic         reset,
    key_sender_if.master bus
);

    localparam logic [SLW-1:0] LAST_SLOT = SLW'(KEY_BYTES - 1);

    state_t                              state_q;
    state_t                              state_d;
    logic [KEY_BYTES-1:0][BYTE_W-1:0]    shadow_q;
    logic [SLW-1:0]                      slot_q;
    logic                                gap_expired;
    logic                                accept;
    logic                                final_beat;

    assign accept = (state_q == SEND) && bus.dready;

`ifdef KEY_PARITY_EN
    // par_q marks that the key bytes are finished and the parity beat is being sent.
    logic              par_q;
    logic [BYTE_W-1:0] parity_byte;

    always_comb begin
        parity_byte = '0;
        for (int i = 0; i < KEY_BYTES; i++) begin
            parity_byte = parity_byte ^ shadow_q[i];
        end
    end

    assign final_beat = par_q;
    assign bus.dout   = par_q ? parity_byte : shadow_q[slot_q];
    assign bus.pbeat  = (state_q == SEND) && par_q;
`else
    assign final_beat = (slot_q == LAST_SLOT);
    assign bus.dout   = shadow_q[slot_q];
    assign bus.pbeat  = 1'b0;
`endif

    assign bus.sl = slot_q;

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bus.busy   = 1'b1;
        bus.dvalid = 1'b0;
        bus.kset   = 1'b0;
        bus.done   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                bus.kset = 1'b1;
                if (bus.start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                bus.dvalid = 1'b1;
                if (bus.dready) begin
                    if (final_beat) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_expired) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                bus.kset = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow key and slot counter; the key word is only sampled on an accepted start.
    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            slot_q   <= '0;
`ifdef KEY_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if ((state_q == IDLE) && bus.start) begin
            shadow_q <= bus.key_in;
            slot_q   <= '0;
`ifdef KEY_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else if (accept && !final_beat) begin
`ifdef KEY_PARITY_EN
            // Parity beat reuses the last slot index rather than advancing past it.
            if (slot_q == LAST_SLOT) begin
                par_q <= 1'b1;
            end else begin
                slot_q <= slot_q + 1'b1;
            end
`else
            slot_q <= slot_q + 1'b1;
`endif
        end
    end

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            gap_timer u_gap_timer (
                .clk      (dclk),
                .rst_n    (reset),
                .load     (accept && !final_beat),
                .load_val (4'(GAP_CYCLES)),
                .en       (state_q == GAP),
                .expired  (gap_expired)
            );
        end else begin : g_no_gap
            assign gap_expired = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_key_sender.sv
// tb_key_sender: randomized self-checking bench for key_sender (GAP_CYCLES=0 and =2 instances).
// Each scenario task drives stimulus and compares against an expected beat list built from the key.
// Honours `KEY_PARITY_EN by appending the XOR parity beat to the expected list.
module tb_key_sender;

    localparam int KB = 4;

    logic        dclk = 1'b0;
    logic        reset;
    logic [31:0] key_in;
    logic        start;
    logic        dready;
    int          sel;

    int checks   = 0;
    int failures = 0;

    always #5 dclk = ~dclk;

    key_sender_if #(.KEY_BYTES(KB)) b0 ();
    key_sender_if #(.KEY_BYTES(KB)) b2 ();

    assign b0.key_in = key_in;
    assign b0.start  = start && (sel == 0);
    assign b0.dready = dready;
    assign b2.key_in = key_in;
    assign b2.start  = start && (sel == 1);
    assign b2.dready = dready;

    key_sender #(.KEY_BYTES(KB), .GAP_CYCLES(0)) dut0 (
        .dclk  (dclk),
        .reset (reset),
        .bus   (b0.master)
    );

    key_sender #(.KEY_BYTES(KB), .GAP_CYCLES(2)) dut2 (
        .dclk  (dclk),
        .reset (reset),
        .bus   (b2.master)
    );

    logic       o_busy, o_dvalid, o_kset, o_pbeat, o_done;
    logic [7:0] o_dout;
    logic [1:0] o_sl;

    always_comb begin
        o_busy   = (sel == 1) ? b2.busy   : b0.busy;
        o_dvalid = (sel == 1) ? b2.dvalid : b0.dvalid;
        o_kset   = (sel == 1) ? b2.kset   : b0.kset;
        o_pbeat  = (sel == 1) ? b2.pbeat  : b0.pbeat;
        o_done   = (sel == 1) ? b2.done   : b0.done;
        o_dout   = (sel == 1) ? b2.dout   : b0.dout;
        o_sl     = (sel == 1) ? b2.sl     : b0.sl;
    end

    // One full load on the selected DUT. Expected beats come from the key bytes
    // (plus parity); timing follows from the gap length and the stalls applied.
    task automatic run_load(input int dut, input logic [31:0] key, input logic [63:0] stall_mask,
                            input int rnd_pct, input int spam_cyc, input string tag);
        logic [7:0] eb[$];
        logic [1:0] es[$];
        bit         ep[$];
        logic [7:0] par;
        int gap, nb, idx, gap_left, phase, cyc, stalls, done_cyc;
        bit dr;
        par = 8'h00;
        for (int i = 0; i < KB; i++) begin
            eb.push_back(key[8*i +: 8]);
            es.push_back(2'(i));
            ep.push_back(1'b0);
            par = par ^ key[8*i +: 8];
        end
`ifdef KEY_PARITY_EN
        eb.push_back(par);
        es.push_back(2'(KB - 1));
        ep.push_back(1'b1);
`endif
        gap      = (dut == 1) ? 2 : 0;
        nb       = eb.size();
        idx      = 0;
        gap_left = 0;
        phase    = 0;
        cyc      = 0;
        stalls   = 0;
        done_cyc = -1;
        sel      = dut;
        @(negedge dclk);
        key_in = key;
        start  = 1'b1;
        dready = 1'b1;
        while (phase < 3 && cyc < 300) begin
            @(negedge dclk);
            cyc++;
            start  = 1'b0;
            key_in = $urandom;
            if (cyc == spam_cyc) begin
                start  = 1'b1;
                key_in = 32'hFFFF_FFFF;
            end
            dr = ($urandom_range(99) >= rnd_pct) && !((cyc < 64) && stall_mask[cyc]);
            if (phase == 2) begin
                checks++;
                if ({o_busy, o_done, o_dvalid, o_kset} !== 4'b0001) begin
                    failures++;
                    $display("FAIL %s idle_after_done cyc%0d busy/done/dvalid/kset=%b want 0001",
                             tag, cyc, {o_busy, o_done, o_dvalid, o_kset});
                end
                phase = 3;
            end else if (phase == 1) begin
                checks++;
                if ({o_busy, o_done, o_dvalid, o_kset} !== 4'b1101) begin
                    failures++;
                    $display("FAIL %s done_cycle cyc%0d busy/done/dvalid/kset=%b want 1101",
                             tag, cyc, {o_busy, o_done, o_dvalid, o_kset});
                end
                done_cyc = cyc;
                phase    = 2;
            end else if (gap_left > 0) begin
                checks++;
                if ({o_busy, o_done, o_dvalid, o_kset} !== 4'b1000) begin
                    failures++;
                    $display("FAIL %s gap cyc%0d busy/done/dvalid/kset=%b want 1000",
                             tag, cyc, {o_busy, o_done, o_dvalid, o_kset});
                end
                gap_left--;
            end else begin
                checks++;
                if ({o_busy, o_done, o_dvalid, o_kset} !== 4'b1010) begin
                    failures++;
                    $display("FAIL %s beat_ctl cyc%0d busy/done/dvalid/kset=%b want 1010",
                             tag, cyc, {o_busy, o_done, o_dvalid, o_kset});
                end
                checks++;
                if ({o_dout, o_sl, o_pbeat} !== {eb[idx], es[idx], ep[idx]}) begin
                    failures++;
                    $display("FAIL %s beat%0d cyc%0d dout=%h sl=%0d pbeat=%b want dout=%h sl=%0d pbeat=%b",
                             tag, idx, cyc, o_dout, o_sl, o_pbeat, eb[idx], es[idx], ep[idx]);
                end
                if (dr) begin
                    idx++;
                    if (idx == nb) phase = 1;
                    else gap_left = gap;
                end else begin
                    stalls++;
                end
            end
            dready = dr;
        end
        start  = 1'b0;
        dready = 1'b1;
        checks++;
        if (phase != 3) begin
            failures++;
            $display("FAIL %s timeout beats_seen=%0d want %0d", tag, idx, nb);
        end
        checks++;
        if (done_cyc != nb * (gap + 1) - gap + 1 + stalls) begin
            failures++;
            $display("FAIL %s done_timing got cycle %0d want %0d", tag, done_cyc,
                     nb * (gap + 1) - gap + 1 + stalls);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        start  = 1'b0;
        dready = 1'b0;
        key_in = 32'h0;
        sel    = 0;
        #12;
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            checks++;
            if ({o_busy, o_dvalid, o_dout, o_sl, o_kset, o_pbeat, o_done} !==
                {1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_state dut%0d busy=%b dvalid=%b dout=%h sl=%0d kset=%b pbeat=%b done=%b want 0 0 00 0 1 0 0",
                         d, o_busy, o_dvalid, o_dout, o_sl, o_kset, o_pbeat, o_done);
            end
        end
        @(negedge dclk);
        reset  = 1'b1;
        dready = 1'b1;
        @(negedge dclk);
    endtask

    task automatic test_basic();
        run_load(0, 32'hA1B2_C3D4, 64'h0, 0, -1, "basic");
    endtask

    task automatic test_backpressure();
        run_load(0, 32'hA1B2_C3D4, 64'h1C, 0, -1, "backpressure");
    endtask

    task automatic test_gap();
        run_load(1, 32'h0102_0304, 64'h0, 0, -1, "gap");
    endtask

    task automatic test_ignored_start();
        run_load(0, 32'h5566_7788, 64'h0, 0, 2, "ignored_start_mid");
        run_load(0, 32'h1234_ABCD, 64'h0, 0, 5, "ignored_start_late");
        run_load(1, 32'h0BAD_F00D, 64'h0, 0, 3, "ignored_start_gap");
    endtask

    task automatic test_back_to_back();
        run_load(0, $urandom, 64'h0, 0, -1, "b2b_0");
        run_load(0, $urandom, 64'h0, 0, -1, "b2b_1");
    endtask

    task automatic test_reset_mid();
        logic [31:0] kv;
        kv  = $urandom;
        sel = 0;
        @(negedge dclk);
        key_in = kv;
        start  = 1'b1;
        dready = 1'b1;
        @(negedge dclk);
        start  = 1'b0;
        key_in = $urandom;
        @(negedge dclk);
        @(negedge dclk);
        checks++;
        if ({o_dvalid, o_sl, o_dout} !== {1'b1, 2'd2, kv[23:16]}) begin
            failures++;
            $display("FAIL reset_mid_pre dvalid=%b sl=%0d dout=%h want 1 2 %h",
                     o_dvalid, o_sl, o_dout, kv[23:16]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_dvalid, o_dout, o_sl, o_kset, o_pbeat, o_done} !==
            {1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_async busy=%b dvalid=%b dout=%h sl=%0d kset=%b pbeat=%b done=%b want 0 0 00 0 1 0 0",
                     o_busy, o_dvalid, o_dout, o_sl, o_kset, o_pbeat, o_done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge dclk);
            checks++;
            if ({o_busy, o_done, o_dvalid} !== 3'b000) begin
                failures++;
                $display("FAIL reset_mid_held cyc%0d busy/done/dvalid=%b want 000",
                         i, {o_busy, o_done, o_dvalid});
            end
        end
        reset = 1'b1;
        @(negedge dclk);
        checks++;
        if ({o_busy, o_done, o_kset} !== 3'b001) begin
            failures++;
            $display("FAIL reset_mid_release busy/done/kset=%b want 001", {o_busy, o_done, o_kset});
        end
        run_load(0, $urandom, 64'h0, 30, -1, "after_reset");
    endtask

    task automatic test_parity();
        run_load(0, 32'hA1B2_C3D4, 64'h0, 0, -1, "parity_nogap");
        run_load(1, 32'hA1B2_C3D4, 64'h0, 0, -1, "parity_gap");
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_load(int'($urandom_range(1)), $urandom, 64'h0, int'($urandom_range(60)), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gap();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
